// File: rtl/pakin_io.sv
// rtl/pakin_io.sv - 4-phase packet receiver with sequence and integrity checking
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 4
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module pakin_io #(
    parameter int MIN_ADDR = 1,
    parameter int MAX_ADDR = 3,
    parameter int ASZ      = `NS_ADDRESS_SIZE,
    parameter int DSZ      = `NS_DATA_SIZE,
    parameter int RSZ      = `NS_REDUN_SIZE,
    parameter int EXP_SRC  = 3,
    parameter int EXP_RED  = 15,
    parameter int EXP_DAT0 = 5,
    parameter int EXP_DST0 = 2
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic [ASZ-1:0] i0_src,
    input  logic [ASZ-1:0] i0_dst,
    input  logic [DSZ-1:0] i0_dat,
    input  logic [RSZ-1:0] i0_red,
    input  logic           i0_req,
    output logic           i0_ack,
    input  logic           i_hold,
    output logic           o_rcv_vld,
    output logic [DSZ-1:0] o_last_dat,
    output logic [15:0]    o_pkt_cnt,
    output logic [7:0]     o_err_cnt,
    output logic           o_err,
    output logic           dbg_busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACK  = 1'b1;

    localparam logic [ASZ-1:0] MIN_A  = ASZ'(MIN_ADDR);
    localparam logic [ASZ-1:0] MAX_A  = ASZ'(MAX_ADDR);
    localparam logic [ASZ-1:0] SRC_A  = ASZ'(EXP_SRC);
    localparam logic [ASZ-1:0] DST_0  = ASZ'(EXP_DST0);
    localparam logic [RSZ-1:0] RED_V  = RSZ'(EXP_RED);
    localparam logic [3:0]     NIB_0  = 4'(EXP_DAT0);

    logic [0:0]     state;
    logic [ASZ-1:0] exp_dst;
    logic [3:0]     exp_nib;
    logic           accept;
    logic           dst_ok;
    logic           pkt_bad;
    logic [ASZ-1:0] next_dst;

    assign i0_ack   = (state == S_ACK);
    assign dbg_busy = i0_ack;

    // Acceptance only from IDLE, so one packet per 4-phase handshake.
    assign accept   = (state == S_IDLE) && i0_req && !i_hold;
    assign dst_ok   = (i0_dst >= MIN_A) && (i0_dst <= MAX_A) && (i0_dst == exp_dst);
    assign pkt_bad  = (i0_src != SRC_A) || !dst_ok || (i0_red != RED_V) ||
                      (i0_dat[3:0] != exp_nib);
    assign next_dst = (exp_dst == MAX_A) ? MIN_A : exp_dst + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            o_rcv_vld  <= 1'b0;
            o_last_dat <= '0;
            o_pkt_cnt  <= '0;
            o_err_cnt  <= '0;
            o_err      <= 1'b0;
            exp_dst    <= DST_0;
            exp_nib    <= NIB_0;
        end else begin
            o_rcv_vld <= accept;
            case (state)
                S_IDLE: if (accept) state <= S_ACK;
                default: if (!i0_req) state <= S_IDLE;
            endcase
            if (accept) begin
                o_last_dat <= i0_dat;
                // Resync the nibble to what arrived so a lost packet costs one error.
                exp_nib    <= i0_dat[3:0] + 4'd1;
                exp_dst    <= next_dst;
                if (o_pkt_cnt != 16'hFFFF)
                    o_pkt_cnt <= o_pkt_cnt + 16'd1;
                if (pkt_bad) begin
                    o_err <= 1'b1;
                    if (o_err_cnt != 8'hFF)
                        o_err_cnt <= o_err_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pakin_io.sv
// tb/tb_pakin_io.sv - directed self-checking bench for pakin_io
module tb_pakin_io;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [3:0] i0_src = '0;
    logic [3:0] i0_dst = '0;
    logic [7:0] i0_dat = '0;
    logic [3:0] i0_red = '0;
    logic       i0_req = 1'b0;
    logic       i0_ack;
    logic       i_hold = 1'b0;
    logic       o_rcv_vld;
    logic [7:0] o_last_dat;
    logic [15:0] o_pkt_cnt;
    logic [7:0] o_err_cnt;
    logic       o_err;
    logic       dbg_busy;

    int checks = 0;
    int failures = 0;

    pakin_io #(
        .ASZ(4), .DSZ(8), .RSZ(4)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i0_src(i0_src), .i0_dst(i0_dst), .i0_dat(i0_dat), .i0_red(i0_red),
        .i0_req(i0_req), .i0_ack(i0_ack), .i_hold(i_hold),
        .o_rcv_vld(o_rcv_vld), .o_last_dat(o_last_dat), .o_pkt_cnt(o_pkt_cnt),
        .o_err_cnt(o_err_cnt), .o_err(o_err), .dbg_busy(dbg_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst  = 1'b1;
        i0_req = 1'b0;
        i_hold = 1'b0;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic send_pkt(input logic [3:0] s, input logic [3:0] d,
                            input logic [7:0] dt, input logic [3:0] r);
        int n;
        i0_src = s; i0_dst = d; i0_dat = dt; i0_red = r;
        i0_req = 1'b1;
        n = 0;
        do begin tick(); n++; end while (!i0_ack && n < 8);
        check("ack_rise", i0_ack, 1);
        check("vld_pulse", o_rcv_vld, 1);
        check("busy_eq_ack", dbg_busy, i0_ack);
        i0_req = 1'b0;
        n = 0;
        do begin tick(); n++; end while (i0_ack && n < 8);
        check("ack_fall", i0_ack, 0);
        check("vld_single", o_rcv_vld, 0);
    endtask

    initial begin
        logic [3:0] d;
        logic [7:0] v;

        // Reset state
        do_reset();
        check("rst_ack", i0_ack, 0);
        check("rst_vld", o_rcv_vld, 0);
        check("rst_last", o_last_dat, 0);
        check("rst_pkt", o_pkt_cnt, 0);
        check("rst_errcnt", o_err_cnt, 0);
        check("rst_err", o_err, 0);

        // Three good packets
        send_pkt(4'd3, 4'd2, 8'd5, 4'd15);
        send_pkt(4'd3, 4'd3, 8'd6, 4'd15);
        send_pkt(4'd3, 4'd1, 8'd7, 4'd15);
        check("good_pkt", o_pkt_cnt, 3);
        check("good_errcnt", o_err_cnt, 0);
        check("good_err", o_err, 0);
        check("good_last", o_last_dat, 7);

        // Lost packet: one error, then resync
        do_reset();
        send_pkt(4'd3, 4'd2, 8'd5, 4'd15);
        send_pkt(4'd3, 4'd3, 8'd7, 4'd15);
        check("skip_errcnt", o_err_cnt, 1);
        send_pkt(4'd3, 4'd1, 8'd8, 4'd15);
        check("resync_errcnt", o_err_cnt, 1);
        check("resync_pkt", o_pkt_cnt, 3);

        // Bad redundancy, bad source, out-of-range destination
        do_reset();
        send_pkt(4'd3, 4'd2, 8'd5, 4'd14);
        check("red_err", o_err, 1);
        check("red_errcnt", o_err_cnt, 1);
        check("red_pkt", o_pkt_cnt, 1);
        send_pkt(4'd2, 4'd3, 8'd6, 4'd15);
        check("src_errcnt", o_err_cnt, 2);
        check("src_pkt", o_pkt_cnt, 2);
        send_pkt(4'd3, 4'd0, 8'd7, 4'd15);
        check("range_errcnt", o_err_cnt, 3);
        send_pkt(4'd3, 4'd2, 8'd8, 4'd15);
        check("range_adv_errcnt", o_err_cnt, 3);
        check("range_adv_pkt", o_pkt_cnt, 4);
        check("sticky_err", o_err, 1);

        // Hold blocks acceptance
        do_reset();
        i0_src = 4'd3; i0_dst = 4'd2; i0_dat = 8'd5; i0_red = 4'd15;
        i_hold = 1'b1;
        i0_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_ack", i0_ack, 0);
        end
        check("hold_pkt", o_pkt_cnt, 0);
        i_hold = 1'b0;
        tick();
        tick();
        check("unhold_ack", i0_ack, 1);
        check("unhold_pkt", o_pkt_cnt, 1);
        i0_req = 1'b0;
        tick();
        tick();
        check("unhold_release", i0_ack, 0);

        // Reset mid-handshake, pending request accepted afterwards
        do_reset();
        send_pkt(4'd3, 4'd2, 8'd5, 4'd15);
        i0_src = 4'd3; i0_dst = 4'd3; i0_dat = 8'd6; i0_red = 4'd15;
        i0_req = 1'b1;
        tick();
        check("pre_rst_ack", i0_ack, 1);
        i_rst = 1'b1;
        tick();
        check("midrst_ack", i0_ack, 0);
        check("midrst_pkt", o_pkt_cnt, 0);
        check("midrst_errcnt", o_err_cnt, 0);
        check("midrst_last", o_last_dat, 0);
        i_rst = 1'b0;
        i0_dst = 4'd2; i0_dat = 8'd5;
        tick();
        check("post_rst_ack", i0_ack, 1);
        check("post_rst_vld", o_rcv_vld, 1);
        check("post_rst_pkt", o_pkt_cnt, 1);
        check("post_rst_errcnt", o_err_cnt, 0);
        i0_req = 1'b0;
        tick();
        tick();

        // Destination and nibble wraparound over a long valid run
        do_reset();
        d = 4'd2;
        v = 8'd5;
        for (int i = 0; i < 40; i++) begin
            send_pkt(4'd3, d, v, 4'd15);
            d = (d == 4'd3) ? 4'd1 : d + 4'd1;
            v = v + 8'd1;
        end
        check("wrap_pkt", o_pkt_cnt, 40);
        check("wrap_errcnt", o_err_cnt, 0);
        check("wrap_err", o_err, 0);
        check("wrap_last", o_last_dat, 8'd44);

        // Error counter saturation
        do_reset();
        for (int i = 0; i < 260; i++)
            send_pkt(4'd2, 4'd0, 8'd0, 4'd0);
        check("sat_errcnt", o_err_cnt, 8'hFF);
        check("sat_pkt", o_pkt_cnt, 260);
        check("sat_err", o_err, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
